ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 130 +++++++++++++
 tb/tb_ex_mem_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, saturating stall counter and an
// optional EX-to-EX forwarding source compiled in by defining EX_MEM_FORWARD_EN.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ValidIn,
    input  logic [DATA_W-1:0] ALUResultIn,
    input  logic              ZeroIn,
    input  logic [DATA_W-1:0] WriteDataIn,
    input  logic [DATA_W-1:0] BranchTargetIn,
    input  logic [REG_W-1:0]  RegDstIn,
    input  logic [4:0]        CtrlIn,
    output logic              ValidOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic              ZeroOut,
    output logic [DATA_W-1:0] WriteDataOut,
    output logic [DATA_W-1:0] BranchTargetOut,
    output logic [REG_W-1:0]  RegDstOut,
    output logic [4:0]        CtrlOut,
    output logic              BranchTaken,
    output logic [15:0]       StallCount,
    output logic              FwdValid,
    output logic [REG_W-1:0]  FwdReg,
    output logic [DATA_W-1:0] FwdData
);

    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_BRANCH   = 0;

    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] alu_q,       alu_d;
    logic              zero_q,      zero_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] btgt_q,      btgt_d;
    logic [REG_W-1:0]  rd_q,        rd_d;
    logic [4:0]        ctrl_q,      ctrl_d;
    logic              taken_q,     taken_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        valid_d     = valid_q;
        alu_d       = alu_q;
        zero_d      = zero_q;
        wdata_d     = wdata_q;
        btgt_d      = btgt_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;
        taken_d     = taken_q;
        stall_cnt_d = stall_cnt_q;
        if (Flush) begin
            valid_d = 1'b0;
            alu_d   = '0;
            zero_d  = 1'b0;
            wdata_d = '0;
            btgt_d  = '0;
            rd_d    = '0;
            ctrl_d  = '0;
            taken_d = 1'b0;
        end else if (Stall) begin
            stall_cnt_d = sat_inc16(stall_cnt_q);
        end else begin
            // A bubble keeps its data fields but must never carry side effects.
            valid_d = ValidIn;
            alu_d   = ALUResultIn;
            zero_d  = ZeroIn;
            wdata_d = WriteDataIn;
            btgt_d  = BranchTargetIn;
            rd_d    = RegDstIn;
            ctrl_d  = ValidIn ? CtrlIn : 5'b0;
            taken_d = ValidIn & CtrlIn[CTRL_BRANCH] & ZeroIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q     <= 1'b0;
            alu_q       <= '0;
            zero_q      <= 1'b0;
            wdata_q     <= '0;
            btgt_q      <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            taken_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            alu_q       <= alu_d;
            zero_q      <= zero_d;
            wdata_q     <= wdata_d;
            btgt_q      <= btgt_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            taken_q     <= taken_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ValidOut        = valid_q;
    assign ALUResultOut    = alu_q;
    assign ZeroOut         = zero_q;
    assign WriteDataOut    = wdata_q;
    assign BranchTargetOut = btgt_q;
    assign RegDstOut       = rd_q;
    assign CtrlOut         = ctrl_q;
    assign BranchTaken     = taken_q;
    assign StallCount      = stall_cnt_q;

`ifdef EX_MEM_FORWARD_EN
    // Loads (MemToReg) are excluded: their value only exists after MEM.
    assign FwdValid = valid_q & ctrl_q[CTRL_REGWRITE] & ~ctrl_q[CTRL_MEMTOREG]
                      & (rd_q != '0);
    assign FwdReg   = rd_q;
    assign FwdData  = alu_q;
`else
    assign FwdValid = 1'b0;
    assign FwdReg   = '0;
    assign FwdData  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized + directed bench for ex_mem_reg against a rule-level reference model.
module tb_ex_mem_reg;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush, ValidIn, ZeroIn;
    logic [31:0] ALUResultIn, WriteDataIn, BranchTargetIn;
    logic [4:0]  RegDstIn, CtrlIn;
    logic        ValidOut, ZeroOut, BranchTaken, FwdValid;
    logic [31:0] ALUResultOut, WriteDataOut, BranchTargetOut, FwdData;
    logic [4:0]  RegDstOut, CtrlOut, FwdReg;
    logic [15:0] StallCount;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic        m_valid, m_zero, m_taken;
    logic [31:0] m_alu, m_wdata, m_btgt;
    logic [4:0]  m_rd, m_ctrl;
    int          m_cnt;

    always #5 Clk = ~Clk;

    ex_mem_reg #(.DATA_W(32), .REG_W(5)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
        .ALUResultIn(ALUResultIn), .ZeroIn(ZeroIn), .WriteDataIn(WriteDataIn),
        .BranchTargetIn(BranchTargetIn), .RegDstIn(RegDstIn), .CtrlIn(CtrlIn),
        .ValidOut(ValidOut), .ALUResultOut(ALUResultOut), .ZeroOut(ZeroOut),
        .WriteDataOut(WriteDataOut), .BranchTargetOut(BranchTargetOut),
        .RegDstOut(RegDstOut), .CtrlOut(CtrlOut), .BranchTaken(BranchTaken),
        .StallCount(StallCount), .FwdValid(FwdValid), .FwdReg(FwdReg), .FwdData(FwdData)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        m_valid = 0; m_zero = 0; m_taken = 0; m_alu = 0; m_wdata = 0;
        m_btgt = 0; m_rd = 0; m_ctrl = 0; m_cnt = 0;
    endtask

    // Priority: reset, flush, stall, load.
    task automatic model_edge();
        if (Rst) begin
            clear_model();
        end else if (Flush) begin
            m_valid = 0; m_zero = 0; m_taken = 0; m_alu = 0; m_wdata = 0;
            m_btgt = 0; m_rd = 0; m_ctrl = 0;
        end else if (Stall) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_valid = ValidIn;
            m_alu   = ALUResultIn;
            m_zero  = ZeroIn;
            m_wdata = WriteDataIn;
            m_btgt  = BranchTargetIn;
            m_rd    = RegDstIn;
            m_ctrl  = ValidIn ? CtrlIn : 5'd0;
            m_taken = ValidIn && CtrlIn[0] && ZeroIn;
        end
    endtask

    task automatic compare_all(input string pfx);
        logic       e_fv;
        logic [4:0] e_fr;
        logic [31:0] e_fd;
`ifdef EX_MEM_FORWARD_EN
        e_fv = m_valid && m_ctrl[4] && !m_ctrl[3] && (m_rd != 0);
        e_fr = m_rd;
        e_fd = m_alu;
`else
        e_fv = 0; e_fr = 0; e_fd = 0;
`endif
        check({pfx, ".valid"}, 64'(ValidOut), 64'(m_valid));
        check({pfx, ".alu"},   64'(ALUResultOut), 64'(m_alu));
        check({pfx, ".zero"},  64'(ZeroOut), 64'(m_zero));
        check({pfx, ".wdata"}, 64'(WriteDataOut), 64'(m_wdata));
        check({pfx, ".btgt"},  64'(BranchTargetOut), 64'(m_btgt));
        check({pfx, ".rd"},    64'(RegDstOut), 64'(m_rd));
        check({pfx, ".ctrl"},  64'(CtrlOut), 64'(m_ctrl));
        check({pfx, ".taken"}, 64'(BranchTaken), 64'(m_taken));
        check({pfx, ".scnt"},  64'(StallCount), 64'(m_cnt));
        check({pfx, ".fwdv"},  64'(FwdValid), 64'(e_fv));
        check({pfx, ".fwdr"},  64'(FwdReg), 64'(e_fr));
        check({pfx, ".fwdd"},  64'(FwdData), 64'(e_fd));
    endtask

    task automatic tick(input string pfx, input bit chk);
        @(posedge Clk);
        model_edge();
        #1;
        if (chk) compare_all(pfx);
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic z,
                         input logic [31:0] wd, input logic [31:0] bt,
                         input logic [4:0] rd, input logic [4:0] ctrl);
        Rst = 0; Flush = 0; Stall = 0;
        ValidIn = v; ALUResultIn = alu; ZeroIn = z; WriteDataIn = wd;
        BranchTargetIn = bt; RegDstIn = rd; CtrlIn = ctrl;
    endtask

    task automatic randomize_inputs();
        ValidIn = 1'($urandom); ALUResultIn = $urandom; ZeroIn = 1'($urandom);
        WriteDataIn = $urandom; BranchTargetIn = $urandom;
        RegDstIn = 5'($urandom); CtrlIn = 5'($urandom);
    endtask

    initial begin
        clear_model();
        drive(0, 0, 0, 0, 0, 0, 0);
        Rst = 1;
        tick("rst0", 1);
        tick("rst1", 1);
        check("rst_valid", 64'(ValidOut), 64'd0);
        check("rst_scnt", 64'(StallCount), 64'd0);

        drive(0, 0, 0, 0, 0, 0, 0);
        tick("release", 1);
        check("release_alu", 64'(ALUResultOut), 64'd0);

        // simple valid ALU instruction writing r8
        drive(1, 32'h5, 0, 32'h77, 32'h0, 5'd8, 5'b10000);
        tick("alu_load", 1);
        check("alu_res", 64'(ALUResultOut), 64'd5);
        check("alu_rd", 64'(RegDstOut), 64'd8);
        check("alu_valid", 64'(ValidOut), 64'd1);
`ifdef EX_MEM_FORWARD_EN
        check("fwd_valid", 64'(FwdValid), 64'd1);
        check("fwd_reg", 64'(FwdReg), 64'd8);
        check("fwd_data", 64'(FwdData), 64'd5);
`endif

        drive(1, 32'h0, 1, 32'h0, 32'h40, 5'd0, 5'b00001);
        tick("br_taken", 1);
        check("br_taken", 64'(BranchTaken), 64'd1);
        check("br_target", 64'(BranchTargetOut), 64'h40);
        drive(1, 32'h3, 0, 32'h0, 32'h40, 5'd0, 5'b00001);
        tick("br_not", 1);
        check("br_not_taken", 64'(BranchTaken), 64'd0);

        // bubble: data captured, control squashed
        drive(0, 32'hABCD, 1, 32'h1234, 32'h80, 5'd9, 5'b11111);
        tick("bubble", 1);
        check("bubble_ctrl", 64'(CtrlOut), 64'd0);
        check("bubble_alu", 64'(ALUResultOut), 64'hABCD);

        // stall holds a valid taken branch for 3 cycles
        drive(1, 32'hDEADBEEF, 1, 32'h55, 32'h100, 5'd4, 5'b10001);
        tick("stall_load", 1);
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            Stall = 1;
            tick("stall", 1);
        end
        check("stall_cnt3", 64'(StallCount), 64'd3);
        check("stall_alu", 64'(ALUResultOut), 64'hDEADBEEF);
        check("stall_taken", 64'(BranchTaken), 64'd1);

        Stall = 1; Flush = 1;
        tick("flush_stall", 1);
        check("fs_valid", 64'(ValidOut), 64'd0);
        check("fs_ctrl", 64'(CtrlOut), 64'd0);
        check("fs_taken", 64'(BranchTaken), 64'd0);
        check("fs_scnt", 64'(StallCount), 64'd3);

        drive(1, 32'h9, 0, 0, 0, 5'd0, 5'b10000);
        tick("fwd_r0", 1);
        check("fwd_r0", 64'(FwdValid), 64'd0);
        drive(1, 32'h9, 0, 0, 0, 5'd3, 5'b11100);
        tick("fwd_ld", 1);
        check("fwd_memtoreg", 64'(FwdValid), 64'd0);

        // reset beats flush and stall together
        randomize_inputs();
        Rst = 1; Stall = 1; Flush = 1;
        tick("rst_prio", 1);
        check("rst_prio_scnt", 64'(StallCount), 64'd0);

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            Rst   = ($urandom_range(0, 31) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            Stall = ($urandom_range(0, 3) == 0);
            tick("rand", 1);
        end

        // saturation of the stall counter
        drive(0, 0, 0, 0, 0, 0, 0);
        Rst = 1;
        tick("sat_rst", 1);
        Rst = 0; Stall = 1;
        for (int i = 0; i < 65534; i++) tick("sat_run", 0);
        compare_all("sat_pre");
        check("sat_fffe", 64'(StallCount), 64'hFFFE);
        tick("sat1", 1);
        check("sat_ffff", 64'(StallCount), 64'hFFFF);
        tick("sat2", 1);
        check("sat_hold", 64'(StallCount), 64'hFFFF);
        Flush = 1;
        tick("sat_flush", 1);
        check("sat_flush_hold", 64'(StallCount), 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
